sys_timer: RTL and testbench



---
 rtl/sys_timer_if.sv | 21 ++
 rtl/sys_timer.sv | 135 +++++++++++++
 tb/tb_sys_timer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_timer_if.sv
// OTTER system bus: word read/write access from the CPU with registered
// read data and error status returned by the secondary.
interface otter_bus;
    logic        wr;
    logic        rd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;

    modport master (
        output wr, rd, size, addr, wdata,
        input  rdata, error
    );

    modport secondary (
        input  wr, rd, size, addr, wdata,
        output rdata, error
    );
endinterface

// File: rtl/sys_timer.sv
// Machine timer on the OTTER system bus: 64-bit mtime/mtimecmp, CTRL.EN and a
// level interrupt. Define SYS_TIMER_PRESCALE_EN to build the DIV clock prescaler.
module sys_timer #(
    parameter int unsigned DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    otter_bus.secondary bus,
    output logic       irq_timer
);

    localparam logic [4:0]  OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0]  OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0]  OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0]  OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0]  OFF_CTRL        = 5'h10;
    localparam logic [15:0] PRESC_LAST      = 16'(DIV - 1);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] rdata_q, rdata_d;
    logic        en_q, en_d;
    logic        error_q, error_d;
    logic        irq_q;
    logic [15:0] presc_cnt;
    logic        tick;
    logic [4:0]  offset;
    logic        access;
    logic        bad;
    logic        wr_ok;
    logic        rd_ok;
    logic [3:0]  unused_region;

    assign offset        = bus.addr[4:0];
    assign unused_region = bus.addr[31:28];
    assign access        = bus.rd | bus.wr;
    // Offsets above CTRL with aligned low bits are exactly the 0x14..0x1C hole.
    assign bad    = (bus.size != 2'd2) || (bus.addr[1:0] != 2'b00) ||
                    (bus.addr[27:5] != 23'd0) || (offset > OFF_CTRL) ||
                    (bus.rd && bus.wr);
    assign wr_ok  = bus.wr && !bad;
    assign rd_ok  = bus.rd && !bad;

`ifdef SYS_TIMER_PRESCALE_EN
    logic [15:0] presc_q, presc_d;

    assign presc_cnt = presc_q;

    always_comb begin
        presc_d = presc_q;
        if (en_q) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= 16'd0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    // No prescaler: pin the count at its wrap value so every enabled clock ticks.
    assign presc_cnt = PRESC_LAST;
`endif

    assign tick = en_q && (presc_cnt == PRESC_LAST);

    always_comb begin
        mtime_d    = mtime_q + {63'd0, tick};
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        shadow_d   = shadow_q;
        rdata_d    = rdata_q;
        error_d    = error_q;

        if (access) begin
            error_d = bad;
            rdata_d = 32'd0;
        end

        // An mtime write replaces the pending tick for the whole 64-bit value.
        if (wr_ok) begin
            case (offset)
                OFF_MTIME_LO:    mtime_d    = {mtime_q[63:32], bus.wdata};
                OFF_MTIME_HI:    mtime_d    = {bus.wdata, mtime_q[31:0]};
                OFF_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], bus.wdata};
                OFF_MTIMECMP_HI: mtimecmp_d = {bus.wdata, mtimecmp_q[31:0]};
                OFF_CTRL:        en_d       = bus.wdata[0];
                default:         ;
            endcase
        end

        if (rd_ok) begin
            case (offset)
                OFF_MTIME_LO: begin
                    rdata_d  = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                OFF_MTIME_HI:    rdata_d = shadow_q;
                OFF_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                OFF_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                OFF_CTRL:        rdata_d = {31'd0, en_q};
                default:         ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_q       <= 1'b1;
            shadow_q   <= 32'd0;
            rdata_q    <= 32'd0;
            error_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.error = error_q;
    assign irq_timer = irq_q;

endmodule

// File: tb/tb_sys_timer.sv
// Directed bench for sys_timer: register access, counting, interrupt timing,
// error decode and reset behaviour.
module tb_sys_timer;

    localparam logic [31:0] A_LO   = 32'h4000_0000;
    localparam logic [31:0] A_HI   = 32'h4000_0004;
    localparam logic [31:0] A_CLO  = 32'h4000_0008;
    localparam logic [31:0] A_CHI  = 32'h4000_000C;
    localparam logic [31:0] A_CTRL = 32'h4000_0010;

    logic clk;
    logic rst_n;
    logic irq_timer;
    int   checks;
    int   failures;

    otter_bus bus ();

`ifdef SYS_TIMER_PRESCALE_EN
    sys_timer #(.DIV(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .irq_timer(irq_timer));
`else
    sys_timer #(.DIV(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .irq_timer(irq_timer));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_op(input logic w, input logic r, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.wr    = w;
        bus.rd    = r;
        bus.size  = sz;
        bus.addr  = a;
        bus.wdata = wd;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] wd);
        bus_op(1'b1, 1'b0, 2'd2, a, wd);
    endtask

    task automatic rd32(input logic [31:0] a);
        bus_op(1'b0, 1'b1, 2'd2, a, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus.rdata); end
        checks++;
        if (bus.error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", bus.error); end
        checks++;
        if (irq_timer !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq_timer); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (10) @(posedge clk);
        rd32(A_LO);
        checks++;
`ifdef SYS_TIMER_PRESCALE_EN
        if (bus.rdata !== 32'd2) begin failures++; $display("FAIL idle_mtime got=%h exp=2", bus.rdata); end
`else
        if (bus.rdata !== 32'd10) begin failures++; $display("FAIL idle_mtime got=%h exp=a", bus.rdata); end
`endif
        checks++;
        if (bus.error !== 1'b0 || irq_timer !== 1'b0) begin
            failures++; $display("FAIL idle_flags got err=%b irq=%b exp 0/0", bus.error, irq_timer);
        end
        rd32(A_CLO);
        checks++;
        if (bus.rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_cmp_lo got=%h exp=ffffffff", bus.rdata); end
        rd32(A_CTRL);
        checks++;
        if (bus.rdata !== 32'd1) begin failures++; $display("FAIL rst_ctrl got=%h exp=1", bus.rdata); end
    endtask

    task automatic test_irq();
        wr32(A_CTRL, 32'd0);
        wr32(A_LO, 32'h10);
        wr32(A_HI, 32'd0);
        wr32(A_CHI, 32'd0);
        wr32(A_CLO, 32'h20);
        wr32(A_CTRL, 32'd1);
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (irq_timer !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq_timer); end
        @(posedge clk); #1;
        checks++;
        if (irq_timer !== 1'b0) begin failures++; $display("FAIL irq_at_match got=%b exp=0", irq_timer); end
        @(posedge clk); #1;
        checks++;
        if (irq_timer !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq_timer); end
        wr32(A_CLO, 32'hFFFF_FFFF);
        checks++;
        if (irq_timer !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", irq_timer); end
        @(posedge clk); #1;
        checks++;
        if (irq_timer !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", irq_timer); end
    endtask

    task automatic test_wrap();
        wr32(A_CTRL, 32'd0);
        wr32(A_LO, 32'hFFFF_FFFE);
        wr32(A_HI, 32'd0);
        wr32(A_CTRL, 32'd1);
        rd32(A_LO);
        checks++;
        if (bus.rdata !== 32'hFFFF_FFFE) begin failures++; $display("FAIL wrap_lo0 got=%h exp=fffffffe", bus.rdata); end
        rd32(A_LO);
        checks++;
        if (bus.rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_lo1 got=%h exp=ffffffff", bus.rdata); end
        rd32(A_HI);
        checks++;
        if (bus.rdata !== 32'd0) begin failures++; $display("FAIL shadow_old got=%h exp=0", bus.rdata); end
        rd32(A_LO);
        checks++;
        if (bus.rdata !== 32'd1) begin failures++; $display("FAIL wrap_lo2 got=%h exp=1", bus.rdata); end
        wr32(A_HI, 32'd7);
        rd32(A_HI);
        checks++;
        if (bus.rdata !== 32'd1) begin failures++; $display("FAIL shadow_snap got=%h exp=1", bus.rdata); end
        rd32(A_LO);
        checks++;
        if (bus.rdata !== 32'd3) begin failures++; $display("FAIL tick_drop got=%h exp=3", bus.rdata); end
        rd32(A_HI);
        checks++;
        if (bus.rdata !== 32'd7) begin failures++; $display("FAIL hi_write got=%h exp=7", bus.rdata); end
    endtask

    task automatic test_errors();
        bus_op(1'b1, 1'b0, 2'd0, A_CLO, 32'h55);
        checks++;
        if (bus.error !== 1'b1) begin failures++; $display("FAIL err_byte got=%b exp=1", bus.error); end
        @(posedge clk); #1;
        checks++;
        if (bus.error !== 1'b1) begin failures++; $display("FAIL err_hold got=%b exp=1", bus.error); end
        bus_op(1'b1, 1'b0, 2'd2, 32'h4000_0002, 32'h55);
        checks++;
        if (bus.error !== 1'b1) begin failures++; $display("FAIL err_align got=%b exp=1", bus.error); end
        rd32(32'h4000_0014);
        checks++;
        if (bus.error !== 1'b1) begin failures++; $display("FAIL err_hole got=%b exp=1", bus.error); end
        bus_op(1'b1, 1'b1, 2'd2, A_CLO, 32'h55);
        checks++;
        if (bus.error !== 1'b1) begin failures++; $display("FAIL err_rdwr got=%b exp=1", bus.error); end
        wr32(32'h4000_0028, 32'h55);
        checks++;
        if (bus.error !== 1'b1) begin failures++; $display("FAIL err_range got=%b exp=1", bus.error); end
        rd32(32'hF000_0008);
        checks++;
        if (bus.error !== 1'b0 || bus.rdata !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL region_ignored got err=%b data=%h exp 0/ffffffff", bus.error, bus.rdata);
        end
        rd32(A_CHI);
        checks++;
`ifdef SYS_TIMER_PRESCALE_EN
        if (bus.rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cmp_hi_kept got=%h exp=ffffffff", bus.rdata); end
`else
        if (bus.rdata !== 32'd0) begin failures++; $display("FAIL cmp_hi_kept got=%h exp=0", bus.rdata); end
`endif
    endtask

    task automatic test_disable();
        wr32(A_CTRL, 32'd0);
        wr32(A_LO, 32'h100);
        repeat (8) @(posedge clk);
        rd32(A_LO);
        checks++;
        if (bus.rdata !== 32'h100) begin failures++; $display("FAIL frozen got=%h exp=100", bus.rdata); end
        wr32(A_CTRL, 32'd1);
        rd32(A_LO);
        checks++;
        if (bus.rdata !== 32'h100) begin failures++; $display("FAIL resume0 got=%h exp=100", bus.rdata); end
        rd32(A_LO);
        checks++;
        if (bus.rdata !== 32'h101) begin failures++; $display("FAIL resume1 got=%h exp=101", bus.rdata); end
        wr32(A_CTRL, 32'd0);
        rd32(A_LO);
        checks++;
        if (bus.rdata !== 32'h103) begin failures++; $display("FAIL disable_tick got=%h exp=103", bus.rdata); end
        rd32(A_LO);
        checks++;
        if (bus.rdata !== 32'h103) begin failures++; $display("FAIL disable_hold got=%h exp=103", bus.rdata); end
    endtask

`ifdef SYS_TIMER_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] exp_tab [5];
        exp_tab[0] = 32'd0; exp_tab[1] = 32'd0; exp_tab[2] = 32'd0;
        exp_tab[3] = 32'd1; exp_tab[4] = 32'd1;
        do_reset();
        wr32(A_CTRL, 32'd0);
        repeat (8) @(posedge clk);
        rd32(A_LO);
        checks++;
        if (bus.rdata !== 32'd0) begin failures++; $display("FAIL pre_frozen got=%h exp=0", bus.rdata); end
        wr32(A_CTRL, 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd32(A_LO);
            checks++;
            if (bus.rdata !== exp_tab[i]) begin
                failures++; $display("FAIL pre_run%0d got=%h exp=%h", i, bus.rdata, exp_tab[i]);
            end
        end
        repeat (2) @(posedge clk);
        rd32(A_LO);
        checks++;
        if (bus.rdata !== exp_tab[4]) begin failures++; $display("FAIL pre_run4 got=%h exp=1", bus.rdata); end
        rd32(A_LO);
        checks++;
        if (bus.rdata !== 32'd2) begin failures++; $display("FAIL pre_run5 got=%h exp=2", bus.rdata); end
    endtask
`endif

    task automatic test_back_to_back_reset();
        wr32(A_CHI, 32'd0);
        wr32(A_CLO, 32'h0000_ABCD);
        rd32(A_CLO);
        checks++;
        if (bus.rdata !== 32'h0000_ABCD) begin failures++; $display("FAIL b2b_read got=%h exp=abcd", bus.rdata); end
        wr32(A_CLO, 32'd0);
        @(posedge clk); #1;
        checks++;
        if (irq_timer !== 1'b1) begin failures++; $display("FAIL pre_rst_irq got=%b exp=1", irq_timer); end
        @(negedge clk);
        bus.wr    = 1'b1;
        bus.size  = 2'd2;
        bus.addr  = A_CLO;
        bus.wdata = 32'h1234_5678;
        rst_n     = 1'b0;
        #1;
        checks++;
        if (bus.rdata !== 32'd0 || bus.error !== 1'b0 || irq_timer !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_out got data=%h err=%b irq=%b exp 0/0/0", bus.rdata, bus.error, irq_timer);
        end
        @(posedge clk);
        @(negedge clk);
        bus.wr = 1'b0;
        rst_n  = 1'b1;
        rd32(A_CLO);
        checks++;
        if (bus.rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mid_rst_cmp_lo got=%h exp=ffffffff", bus.rdata); end
        rd32(A_CHI);
        checks++;
        if (bus.rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mid_rst_cmp_hi got=%h exp=ffffffff", bus.rdata); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.wr    = 1'b0;
        bus.rd    = 1'b0;
        bus.size  = 2'd2;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
        test_reset();
`ifdef SYS_TIMER_PRESCALE_EN
        test_errors();
        test_prescale();
`else
        test_irq();
        test_wrap();
        test_errors();
        test_disable();
`endif
        test_back_to_back_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
